// File: rtl/au_bitscan_encode_if.sv
// Handshake bundle for the sequential multi-hot encoder: word input side and index output side.
interface au_bitscan_encode_if #(
    parameter int WIDTH = 8
);
    localparam int M = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic             out_valid;
    logic             out_ready;
    logic [M-1:0]     z;
    logic             out_last;
    logic             out_zero;

    modport master (
        output in_valid, a, out_ready,
        input  in_ready, out_valid, z, out_last, out_zero
    );

    modport slave (
        input  in_valid, a, out_ready,
        output in_ready, out_valid, z, out_last, out_zero
    );
endinterface

// File: rtl/au_bitscan_encode.sv
// Sequential multi-hot encoder: emits the index of every set bit of an accepted word,
// one index per output beat, LSB-first or MSB-first, with zero-word signalling.
module au_bitscan_encode #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input logic             clk,
    input logic             rst_n,
    au_bitscan_encode_if.slave bus
);
    localparam int M = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SCAN = 1'b1;

    logic [0:0]       state_r;
    logic [WIDTH-1:0] mask_r;
    logic             zflag_r;

    logic             busy_s;
    logic [M-1:0]     cur_idx_s;
    logic             single_s;
    logic             last_s;
    logic             in_fire_s;
    logic             out_fire_s;
    logic [WIDTH-1:0] mask_cleared_s;

    // Index of the next bit to emit; the last assignment in scan order wins.
    function automatic logic [M-1:0] scan_index(input logic [WIDTH-1:0] v);
        logic [M-1:0] idx;
        idx = {M{1'b0}};
        if (MSB_FIRST) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (v[i]) idx = i[M-1:0];
                else      idx = idx;
            end
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (v[i]) idx = i[M-1:0];
                else      idx = idx;
            end
        end
        return idx;
    endfunction

    // True when exactly one bit of v is set.
    function automatic logic is_single(input logic [WIDTH-1:0] v);
        logic seen;
        logic multi;
        seen  = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) begin
                multi = multi | seen;
                seen  = 1'b1;
            end else begin
                seen  = seen;
            end
        end
        return seen & ~multi;
    endfunction

    // Current-beat decode and handshake qualification.
    always_comb begin
        busy_s    = (state_r == ST_SCAN);
        cur_idx_s = scan_index(mask_r);
        single_s  = is_single(mask_r);
        last_s    = busy_s & (zflag_r | single_s);
        mask_cleared_s = mask_r;
        mask_cleared_s[cur_idx_s] = 1'b0;
        in_fire_s  = bus.in_valid & bus.in_ready;
        out_fire_s = busy_s & bus.out_ready;
    end

    // Output drive; in_ready bypasses on the last beat so consecutive words need no bubble.
    always_comb begin
        bus.out_valid = busy_s;
        bus.out_last  = last_s;
        bus.out_zero  = busy_s & zflag_r;
        bus.in_ready  = ~busy_s | (last_s & bus.out_ready);
        if (zflag_r) begin
            bus.z = {M{1'b0}};
        end else begin
            bus.z = cur_idx_s;
        end
    end

    // Scan state: load on accept, retire one set bit per output handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            mask_r  <= {WIDTH{1'b0}};
            zflag_r <= 1'b0;
        end else if (in_fire_s) begin
            state_r <= ST_SCAN;
            mask_r  <= bus.a;
            zflag_r <= (bus.a == {WIDTH{1'b0}});
        end else if (out_fire_s) begin
            mask_r <= mask_cleared_s;
            if (last_s) begin
                state_r <= ST_IDLE;
            end else begin
                state_r <= ST_SCAN;
            end
        end else begin
            state_r <= state_r;
            mask_r  <= mask_r;
            zflag_r <= zflag_r;
        end
    end
endmodule

// File: tb/tb_au_bitscan_encode.sv
// Directed bench for au_bitscan_encode: LSB/MSB-first 8-bit, 5-bit and 1-bit instances share stimulus.
module tb_au_bitscan_encode;
    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] a;
    logic       out_ready;

    int checks;
    int errors;

    logic [2:0] cz    [16];
    logic       cl    [16];
    logic       czero [16];
    int         cn;

    au_bitscan_encode_if #(.WIDTH(8)) b8l ();
    au_bitscan_encode_if #(.WIDTH(8)) b8m ();
    au_bitscan_encode_if #(.WIDTH(5)) b5 ();
    au_bitscan_encode_if #(.WIDTH(1)) b1 ();

    assign b8l.in_valid = in_valid;
    assign b8l.a        = a;
    assign b8l.out_ready = out_ready;
    assign b8m.in_valid = in_valid;
    assign b8m.a        = a;
    assign b8m.out_ready = out_ready;
    assign b5.in_valid  = in_valid;
    assign b5.a         = a[4:0];
    assign b5.out_ready = out_ready;
    assign b1.in_valid  = in_valid;
    assign b1.a         = a[0:0];
    assign b1.out_ready = out_ready;

    au_bitscan_encode #(.WIDTH(8), .MSB_FIRST(1'b0)) u8l (.clk(clk), .rst_n(rst_n), .bus(b8l.slave));
    au_bitscan_encode #(.WIDTH(8), .MSB_FIRST(1'b1)) u8m (.clk(clk), .rst_n(rst_n), .bus(b8m.slave));
    au_bitscan_encode #(.WIDTH(5), .MSB_FIRST(1'b0)) u5  (.clk(clk), .rst_n(rst_n), .bus(b5.slave));
    au_bitscan_encode #(.WIDTH(1), .MSB_FIRST(1'b0)) u1  (.clk(clk), .rst_n(rst_n), .bus(b1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input int sel, output logic v, output logic [2:0] zz,
                          output logic l, output logic zr, output logic ir);
        case (sel)
            0: begin v = b8l.out_valid; zz = b8l.z; l = b8l.out_last; zr = b8l.out_zero; ir = b8l.in_ready; end
            1: begin v = b8m.out_valid; zz = b8m.z; l = b8m.out_last; zr = b8m.out_zero; ir = b8m.in_ready; end
            2: begin v = b5.out_valid;  zz = b5.z;  l = b5.out_last;  zr = b5.out_zero;  ir = b5.in_ready;  end
            default: begin v = b1.out_valid; zz = {2'b00, b1.z}; l = b1.out_last; zr = b1.out_zero; ir = b1.in_ready; end
        endcase
    endtask

    // Present one word, then record every beat of instance sel until its last beat.
    task automatic collect(input int sel, input logic [7:0] word, input int maxc);
        logic v, l, zr, ir;
        logic [2:0] zz;
        for (int k = 0; k < 16; k++) begin
            cz[k] = 3'bxxx; cl[k] = 1'bx; czero[k] = 1'bx;
        end
        cn = 0;
        in_valid = 1'b1; a = word; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < maxc; k++) begin
            sample(sel, v, zz, l, zr, ir);
            if (v) begin
                cz[cn] = zz; cl[cn] = l; czero[cn] = zr;
                cn++;
            end
            step();
            if (v && l) break;
        end
        for (int k = 0; k < 3; k++) step();
    endtask

    task automatic test_reset();
        logic v, l, zr, ir;
        logic [2:0] zz;
        rst_n = 1'b0; in_valid = 1'b0; a = 8'h00; out_ready = 1'b0;
        #1;
        for (int s = 0; s < 4; s++) begin
            sample(s, v, zz, l, zr, ir);
            checks++;
            if ({v, zz, l, zr, ir} !== {1'b0, 3'd0, 1'b0, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL reset_state dut%0d: got v=%b z=%0d last=%b zero=%b rdy=%b, want 0 0 0 0 1", s, v, zz, l, zr, ir);
            end
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        for (int s = 0; s < 2; s++) begin
            collect(s, 8'h20, 6);
            checks++;
            if (cn !== 1 || cz[0] !== 3'd5 || cl[0] !== 1'b1 || czero[0] !== 1'b0) begin
                errors++;
                $display("FAIL single_bit dut%0d: got beats=%0d z=%0d last=%b zero=%b, want 1 5 1 0", s, cn, cz[0], cl[0], czero[0]);
            end
        end
    endtask

    task automatic test_order();
        logic [2:0] exp_a [4];
        logic [2:0] exp_d [4];
        exp_a = '{3'd0, 3'd2, 3'd5, 3'd7};
        exp_d = '{3'd7, 3'd5, 3'd2, 3'd0};
        for (int s = 0; s < 2; s++) begin
            collect(s, 8'hA5, 10);
            checks++;
            if (cn !== 4) begin
                errors++;
                $display("FAIL order_count dut%0d: got %0d beats, want 4", s, cn);
            end
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (cz[k] !== ((s == 0) ? exp_a[k] : exp_d[k]) || cl[k] !== (k == 3)) begin
                    errors++;
                    $display("FAIL order_beat dut%0d beat%0d: got z=%0d last=%b, want z=%0d last=%b",
                             s, k, cz[k], cl[k], (s == 0) ? exp_a[k] : exp_d[k], (k == 3));
                end
            end
        end
    endtask

    task automatic test_zero();
        logic v, l, zr, ir;
        logic [2:0] zz;
        in_valid = 1'b1; a = 8'h00; out_ready = 1'b1;
        step();
        a = 8'h02;
        sample(0, v, zz, l, zr, ir);
        checks++;
        if ({v, zz, l, zr, ir} !== {1'b1, 3'd0, 1'b1, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL zero_beat: got v=%b z=%0d last=%b zero=%b rdy=%b, want 1 0 1 1 1", v, zz, l, zr, ir);
        end
        step();
        in_valid = 1'b0;
        sample(0, v, zz, l, zr, ir);
        checks++;
        if ({v, zz, l, zr} !== {1'b1, 3'd1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL zero_next_word: got v=%b z=%0d last=%b zero=%b, want 1 1 1 0", v, zz, l, zr);
        end
        step();
        sample(0, v, zz, l, zr, ir);
        checks++;
        if (v !== 1'b0) begin
            errors++;
            $display("FAIL zero_idle: got out_valid=%b, want 0", v);
        end
        repeat (3) step();
    endtask

    task automatic test_backpressure();
        logic v, l, zr, ir;
        logic [2:0] zz;
        in_valid = 1'b1; a = 8'h81; out_ready = 1'b0;
        step();
        in_valid = 1'b0; a = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            sample(0, v, zz, l, zr, ir);
            checks++;
            if ({v, zz, l} !== {1'b1, 3'd0, 1'b0}) begin
                errors++;
                $display("FAIL stall_hold cycle%0d: got v=%b z=%0d last=%b, want 1 0 0", k, v, zz, l);
            end
            step();
        end
        out_ready = 1'b1;
        sample(0, v, zz, l, zr, ir);
        checks++;
        if ({v, zz, l} !== {1'b1, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL stall_release: got v=%b z=%0d last=%b, want 1 0 0", v, zz, l);
        end
        step();
        sample(0, v, zz, l, zr, ir);
        checks++;
        if ({v, zz, l} !== {1'b1, 3'd7, 1'b1}) begin
            errors++;
            $display("FAIL stall_second: got v=%b z=%0d last=%b, want 1 7 1", v, zz, l);
        end
        repeat (3) step();
    endtask

    task automatic test_back_to_back();
        logic v, l, zr, ir;
        logic [2:0] zz;
        in_valid = 1'b1; a = 8'h03; out_ready = 1'b1;
        step();
        a = 8'h40;
        sample(0, v, zz, l, zr, ir);
        checks++;
        if ({v, zz, l, ir} !== {1'b1, 3'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL b2b_first: got v=%b z=%0d last=%b rdy=%b, want 1 0 0 0", v, zz, l, ir);
        end
        step();
        sample(0, v, zz, l, zr, ir);
        checks++;
        if ({v, zz, l, ir} !== {1'b1, 3'd1, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL b2b_last: got v=%b z=%0d last=%b rdy=%b, want 1 1 1 1", v, zz, l, ir);
        end
        step();
        in_valid = 1'b0;
        sample(0, v, zz, l, zr, ir);
        checks++;
        if ({v, zz, l} !== {1'b1, 3'd6, 1'b1}) begin
            errors++;
            $display("FAIL b2b_second_word: got v=%b z=%0d last=%b, want 1 6 1", v, zz, l);
        end
        repeat (4) step();
    endtask

    task automatic test_width5_reset();
        logic v, l, zr, ir;
        logic [2:0] zz;
        logic [2:0] exp5 [3];
        exp5 = '{3'd1, 3'd2, 3'd4};
        collect(2, 8'h16, 8);
        checks++;
        if (cn !== 3) begin
            errors++;
            $display("FAIL w5_count: got %0d beats, want 3", cn);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (cz[k] !== exp5[k] || cl[k] !== (k == 2)) begin
                errors++;
                $display("FAIL w5_beat%0d: got z=%0d last=%b, want z=%0d last=%b", k, cz[k], cl[k], exp5[k], (k == 2));
            end
        end
        in_valid = 1'b1; a = 8'h16; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        sample(2, v, zz, l, zr, ir);
        checks++;
        if ({v, zz} !== {1'b1, 3'd2}) begin
            errors++;
            $display("FAIL w5_pre_reset: got v=%b z=%0d, want 1 2", v, zz);
        end
        rst_n = 1'b0;
        #1;
        sample(2, v, zz, l, zr, ir);
        checks++;
        if (v !== 1'b0) begin
            errors++;
            $display("FAIL w5_async_reset: got out_valid=%b, want 0", v);
        end
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        step();
        for (int k = 0; k < 3; k++) begin
            sample(2, v, zz, l, zr, ir);
            checks++;
            if ({v, ir} !== {1'b0, 1'b1}) begin
                errors++;
                $display("FAIL w5_no_stale cycle%0d: got v=%b rdy=%b, want 0 1", k, v, ir);
            end
            step();
        end
    endtask

    task automatic test_width1();
        collect(3, 8'h01, 4);
        checks++;
        if (cn !== 1 || cz[0] !== 3'd0 || cl[0] !== 1'b1 || czero[0] !== 1'b0) begin
            errors++;
            $display("FAIL w1_one: got beats=%0d z=%0d last=%b zero=%b, want 1 0 1 0", cn, cz[0], cl[0], czero[0]);
        end
        collect(3, 8'h00, 4);
        checks++;
        if (cn !== 1 || cz[0] !== 3'd0 || cl[0] !== 1'b1 || czero[0] !== 1'b1) begin
            errors++;
            $display("FAIL w1_zero: got beats=%0d z=%0d last=%b zero=%b, want 1 0 1 1", cn, cz[0], cl[0], czero[0]);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_order();
        test_zero();
        test_backpressure();
        test_back_to_back();
        test_width5_reset();
        test_width1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
